// File: rtl/dmem_pkg.sv
// Shared definitions for the data-RAM arbiter: dump FSM state encoding and default widths.
package dmem_pkg;

  localparam int unsigned NB_DATA_DEF = 32;
  localparam int unsigned NB_ADDR_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_FETCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } dmem_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the pipeline MEM stage and a dump
// sequencer that streams words 0..DUMP_WORDS-1 to the debug unit over valid/ready.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned NB_DATA    = NB_DATA_DEF,
  parameter int unsigned NB_ADDR    = NB_ADDR_DEF,
  parameter int unsigned DUMP_WORDS = 256
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_mem_re,
  input  logic               i_mem_we,
  input  logic [NB_ADDR-1:0] i_mem_addr,
  input  logic [NB_DATA-1:0] i_mem_wdata,
  output logic [NB_DATA-1:0] o_mem_rdata,
  output logic               o_pipe_stall,
  input  logic               i_dump_start,
  input  logic               i_dump_abort,
  output logic               o_dump_busy,
  output logic               o_dump_valid,
  input  logic               i_dump_ready,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic               o_dump_done,
  output logic               o_ram_we,
  output logic [NB_ADDR-1:0] o_ram_addr,
  output logic [NB_DATA-1:0] o_ram_wdata,
  input  logic [NB_DATA-1:0] i_ram_rdata
);

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(DUMP_WORDS - 1);

  dmem_state_e        state_q, state_d;
  logic [NB_ADDR-1:0] cnt_q, cnt_d;
  logic [NB_ADDR-1:0] dump_addr_q, dump_addr_d;
  logic [NB_DATA-1:0] dump_data_q, dump_data_d;
  logic               dump_owns;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_dump_start) begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
      end
      ST_ARM: begin
        state_d = i_dump_abort ? ST_IDLE : ST_FETCH;
      end
      ST_FETCH: begin
        dump_data_d = i_ram_rdata;
        dump_addr_d = cnt_q;
        state_d     = i_dump_abort ? ST_IDLE : ST_SEND;
      end
      ST_SEND: begin
        // Abort takes priority over a handshake in the same cycle.
        if (i_dump_abort) begin
          state_d = ST_IDLE;
        end else if (i_dump_ready) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + NB_ADDR'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
    end
  end

  // ARM still belongs to the pipeline so an access issued alongside the start completes.
  assign dump_owns = (state_q == ST_FETCH) || (state_q == ST_SEND) || (state_q == ST_DONE);

  assign o_ram_we     = i_mem_we & ~dump_owns;
  assign o_ram_addr   = dump_owns ? cnt_q : i_mem_addr;
  assign o_ram_wdata  = dump_owns ? '0 : i_mem_wdata;
  assign o_mem_rdata  = i_ram_rdata;
  assign o_pipe_stall = dump_owns & (i_mem_re | i_mem_we);

  assign o_dump_busy  = (state_q == ST_ARM) || (state_q == ST_FETCH) || (state_q == ST_SEND);
  assign o_dump_valid = (state_q == ST_SEND);
  assign o_dump_done  = (state_q == ST_DONE);
  assign o_dump_data  = dump_data_q;
  assign o_dump_addr  = dump_addr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vectors and sequences, then random traffic
// checked against a transaction-level model of the dump stream and RAM ownership.
module tb_dmem_arbiter;

  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_mem_re, i_mem_we;
  logic [7:0]  i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic [31:0] o_mem_rdata;
  logic        o_pipe_stall;
  logic        i_dump_start, i_dump_abort, i_dump_ready;
  logic        o_dump_busy, o_dump_valid, o_dump_done;
  logic [31:0] o_dump_data;
  logic [7:0]  o_dump_addr;
  logic        o_ram_we;
  logic [7:0]  o_ram_addr;
  logic [31:0] o_ram_wdata;
  logic [31:0] i_ram_rdata;

  logic [31:0] ram [256];

  int total = 0;
  int bad = 0;

  logic [39:0] got[$];
  logic [31:0] mm [8];
  logic [31:0] exp_words [NW];
  bit          dump_on, first_c, done_now, n_done, owned, hs, hold;
  int          exp_idx;

  always #5 clk = ~clk;

  assign i_ram_rdata = ram[o_ram_addr];
  always @(posedge clk) if (o_ram_we) ram[o_ram_addr] <= o_ram_wdata;

  dmem_arbiter #(
    .NB_DATA    (32),
    .NB_ADDR    (8),
    .DUMP_WORDS (NW)
  ) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_mem_re     (i_mem_re),
    .i_mem_we     (i_mem_we),
    .i_mem_addr   (i_mem_addr),
    .i_mem_wdata  (i_mem_wdata),
    .o_mem_rdata  (o_mem_rdata),
    .o_pipe_stall (o_pipe_stall),
    .i_dump_start (i_dump_start),
    .i_dump_abort (i_dump_abort),
    .o_dump_busy  (o_dump_busy),
    .o_dump_valid (o_dump_valid),
    .i_dump_ready (i_dump_ready),
    .o_dump_data  (o_dump_data),
    .o_dump_addr  (o_dump_addr),
    .o_dump_done  (o_dump_done),
    .o_ram_we     (o_ram_we),
    .o_ram_addr   (o_ram_addr),
    .o_ram_wdata  (o_ram_wdata),
    .i_ram_rdata  (i_ram_rdata)
  );

  typedef struct packed {
    logic        we;
    logic        re;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    i_mem_re = 0; i_mem_we = 0; i_mem_addr = 0; i_mem_wdata = 0;
    i_dump_start = 0; i_dump_abort = 0; i_dump_ready = 1;
  endtask

  task automatic record();
    if (o_dump_valid && i_dump_ready && !i_dump_abort) got.push_back({o_dump_addr, o_dump_data});
  endtask

  task automatic chk_stream(input string nm);
    chk({nm, "_count"}, got.size(), NW);
    for (int k = 0; k < NW; k++) begin
      if (k < got.size()) begin
        chk({nm, "_addr"}, 32'(got[k][39:32]), k);
        chk({nm, "_data"}, got[k][31:0], exp_words[k]);
      end
    end
  endtask

  initial begin
    clr();
    i_rst_n = 1;
    #1 i_rst_n = 0;
    #1;
    chk("rst_busy", o_dump_busy, 0);
    chk("rst_valid", o_dump_valid, 0);
    chk("rst_done", o_dump_done, 0);
    chk("rst_stall", o_pipe_stall, 0);
    chk("rst_ram_we", o_ram_we, 0);
    chk("rst_dump_data", o_dump_data, 0);
    chk("rst_dump_addr", 32'(o_dump_addr), 0);
    cyc(); cyc();
    i_rst_n = 1;
    cyc();

    // Idle passthrough vectors; the writes also preload RAM[i] = 0x100 + i.
    vt[0] = '{we: 1, re: 0, addr: 8'h10, wdata: 32'hDEADBEEF, rdata: 32'h0};
    vt[1] = '{we: 0, re: 1, addr: 8'h10, wdata: 32'h0, rdata: 32'hDEADBEEF};
    vt[2] = '{we: 1, re: 0, addr: 8'h00, wdata: 32'h100, rdata: 32'h0};
    vt[3] = '{we: 1, re: 0, addr: 8'h01, wdata: 32'h101, rdata: 32'h0};
    vt[4] = '{we: 1, re: 0, addr: 8'h02, wdata: 32'h102, rdata: 32'h0};
    vt[5] = '{we: 1, re: 0, addr: 8'h03, wdata: 32'h103, rdata: 32'h0};
    vt[6] = '{we: 0, re: 1, addr: 8'h02, wdata: 32'h0, rdata: 32'h102};
    vt[7] = '{we: 0, re: 1, addr: 8'h00, wdata: 32'h0, rdata: 32'h100};
    for (int i = 0; i < 8; i++) begin
      i_mem_we = vt[i].we; i_mem_re = vt[i].re;
      i_mem_addr = vt[i].addr; i_mem_wdata = vt[i].wdata;
      @(negedge clk);
      chk("pass_ram_we", o_ram_we, vt[i].we);
      chk("pass_ram_addr", 32'(o_ram_addr), 32'(vt[i].addr));
      chk("pass_stall", o_pipe_stall, 0);
      if (vt[i].we) chk("pass_ram_wdata", o_ram_wdata, vt[i].wdata);
      if (vt[i].re) chk("pass_rdata", o_mem_rdata, vt[i].rdata);
      cyc();
    end
    clr();

    // Full dump with ready high: word k visible at cycle 3+2k, done at 2+2*NW.
    for (int k = 0; k < NW; k++) exp_words[k] = 32'h100 + k;
    got.delete();
    i_dump_start = 1;
    @(negedge clk);
    cyc();
    i_dump_start = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      record();
      chk("full_valid", o_dump_valid, (c >= 3 && c <= 2 * NW + 1 && (c % 2) == 1));
      chk("full_done", o_dump_done, (c == 2 + 2 * NW));
      chk("full_busy", o_dump_busy, (c >= 1 && c <= 2 * NW + 1));
      cyc();
    end
    chk_stream("full");

    // Backpressure on word 2 (SEND at cycle 7) for 5 cycles.
    got.delete();
    i_dump_start = 1;
    @(negedge clk);
    cyc();
    i_dump_start = 0;
    for (int c = 1; c <= 18; c++) begin
      i_dump_ready = !(c >= 7 && c <= 11);
      @(negedge clk);
      record();
      if (c >= 7 && c <= 11) begin
        chk("bp_valid", o_dump_valid, 1);
        chk("bp_data", o_dump_data, 32'h102);
        chk("bp_addr", 32'(o_dump_addr), 2);
      end
      chk("bp_done", o_dump_done, (c == 15));
      cyc();
    end
    i_dump_ready = 1;
    chk_stream("bp");

    // Contention: write in the start cycle and in ARM land; a held write is stalled.
    got.delete();
    i_dump_start = 1; i_mem_we = 1; i_mem_addr = 8'h02; i_mem_wdata = 32'h55;
    @(negedge clk);
    chk("ct_start_we", o_ram_we, 1);
    chk("ct_start_stall", o_pipe_stall, 0);
    cyc();
    i_dump_start = 0; i_mem_addr = 8'h01; i_mem_wdata = 32'h77;
    @(negedge clk);
    chk("ct_arm_we", o_ram_we, 1);
    chk("ct_arm_stall", o_pipe_stall, 0);
    chk("ct_arm_busy", o_dump_busy, 1);
    cyc();
    i_mem_addr = 8'h03; i_mem_wdata = 32'h99;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      record();
      chk("ct_stall", o_pipe_stall, 1);
      chk("ct_ram_we", o_ram_we, 0);
      chk("ct_done", o_dump_done, (c == 10));
      cyc();
    end
    @(negedge clk);
    chk("ct_idle_stall", o_pipe_stall, 0);
    chk("ct_idle_we", o_ram_we, 1);
    cyc();
    exp_words[1] = 32'h77; exp_words[2] = 32'h55;
    chk_stream("ct");
    i_mem_we = 0; i_mem_re = 1;
    i_mem_addr = 8'h03;
    @(negedge clk); chk("ct_rd3", o_mem_rdata, 32'h99); cyc();
    i_mem_addr = 8'h01;
    @(negedge clk); chk("ct_rd1", o_mem_rdata, 32'h77); cyc();
    clr();

    // Abort during SEND of word 1 (cycle 5) together with ready high.
    i_dump_start = 1;
    @(negedge clk);
    cyc();
    i_dump_start = 0;
    for (int c = 1; c <= 12; c++) begin
      i_dump_abort = (c == 5);
      @(negedge clk);
      if (c == 5) begin
        chk("ab_valid_before", o_dump_valid, 1);
        chk("ab_addr_before", 32'(o_dump_addr), 1);
      end
      if (c >= 6) begin
        chk("ab_busy", o_dump_busy, 0);
        chk("ab_valid", o_dump_valid, 0);
        chk("ab_done", o_dump_done, 0);
      end
      cyc();
    end
    i_dump_abort = 0;
    i_dump_start = 1;
    @(negedge clk);
    cyc();
    i_dump_start = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 3) begin
        chk("re_valid", o_dump_valid, 1);
        chk("re_addr", 32'(o_dump_addr), 0);
        chk("re_data", o_dump_data, 32'h100);
      end
      cyc();
    end

    // Reset asserted in FETCH (cycle 2) with a pipeline read pending.
    i_dump_start = 1;
    @(negedge clk);
    cyc();
    i_dump_start = 0;
    cyc();
    i_mem_re = 1;
    @(negedge clk);
    chk("rf_stall_pre", o_pipe_stall, 1);
    i_rst_n = 0;
    #1;
    chk("rf_busy", o_dump_busy, 0);
    chk("rf_valid", o_dump_valid, 0);
    chk("rf_done", o_dump_done, 0);
    chk("rf_stall", o_pipe_stall, 0);
    chk("rf_ram_we", o_ram_we, 0);
    chk("rf_dump_data", o_dump_data, 0);
    chk("rf_dump_addr", 32'(o_dump_addr), 0);
    cyc();
    i_rst_n = 1;
    clr();
    cyc();

    // Random traffic against a transaction-level model.
    for (int i = 0; i < 8; i++) begin
      mm[i] = $urandom;
      i_mem_we = 1; i_mem_addr = 8'(i); i_mem_wdata = mm[i];
      cyc();
    end
    clr();
    dump_on = 0; first_c = 0; done_now = 0; exp_idx = 0; hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        int op;
        op = $urandom_range(0, 3);
        i_mem_re = (op == 1);
        i_mem_we = (op == 2);
        i_mem_addr = 8'($urandom_range(0, 7));
        i_mem_wdata = $urandom;
      end
      i_dump_start = ($urandom_range(0, 15) == 0);
      i_dump_abort = ($urandom_range(0, 39) == 0);
      i_dump_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      owned = (dump_on && !first_c) || done_now;
      chk("rnd_busy", o_dump_busy, dump_on);
      chk("rnd_done", o_dump_done, done_now);
      chk("rnd_stall", o_pipe_stall, owned && (i_mem_re || i_mem_we));
      chk("rnd_ram_we", o_ram_we, i_mem_we && !owned);
      chk("rnd_valid_phase", o_dump_valid && !(dump_on && !first_c), 0);
      if (i_mem_re && !owned) chk("rnd_rdata", o_mem_rdata, mm[i_mem_addr[2:0]]);
      hs = o_dump_valid && i_dump_ready && !i_dump_abort;
      if (hs) begin
        chk("rnd_dump_addr", 32'(o_dump_addr), exp_idx);
        chk("rnd_dump_data", o_dump_data, mm[exp_idx]);
      end
      n_done = 0;
      if (dump_on) begin
        if (i_dump_abort) dump_on = 0;
        else if (hs) begin
          if (exp_idx == NW - 1) begin
            dump_on = 0;
            n_done = 1;
          end else begin
            exp_idx++;
          end
        end
        first_c = 0;
      end else if (i_dump_start && !done_now) begin
        dump_on = 1;
        first_c = 1;
        exp_idx = 0;
      end
      if (i_mem_we && !owned) mm[i_mem_addr[2:0]] = i_mem_wdata;
      done_now = n_done;
      hold = o_pipe_stall;
      cyc();
    end
    clr();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
